// File: rtl/pipeline_reg_wb_skid.sv
// ---------------------------------------------------------------------------
// pipeline_reg_wb_skid
//
// MEM/WB pipeline register with a one-entry skid buffer. The main register
// drives the writeback outputs; the skid register holds a second beat so the
// upstream stage sees a registered ready signal with no combinational path
// from out_ready.
//
// Parameters
//   XLEN  ALU-result and memory-data width in bits
//   RD_W  destination-register index width
//
// Ports
//   clock           single clock, all state updates on the rising edge
//   reset           asynchronous active-low reset
//   in_valid        upstream beat present
//   in_ready        block can accept a beat (registered)
//   flush           synchronous discard of all held beats
//   regwrite_in     register-write enable of the incoming beat
//   memtoreg_in     writeback source select of the incoming beat
//   alu_result_in   ALU result of the incoming beat
//   mem_data_in     memory read data of the incoming beat
//   rd_in           destination register index of the incoming beat
//   out_valid       writeback beat present
//   out_ready       writeback stage consumes the beat
//   regwrite_out    stored register-write enable, gated by out_valid
//   memtoreg_out    stored writeback source select
//   alu_result_out  stored ALU result
//   mem_data_out    stored memory data
//   rd_out          stored destination register index
//   wb_data_out     selected writeback data (memtoreg ? mem : alu)
//   occupancy       number of held beats (0..2)
//
// Configuration macro
//   PIPE_WB_X0_SUPPRESS_EN  when defined, beats targeting x0 are stored with
//                           regwrite cleared
//
// States
//   ST_EMPTY | no beat held, payload outputs keep the last loaded values
//   ST_ONE   | one beat held in the main register
//   ST_FULL  | main and skid registers both hold a beat, in_ready low
// ---------------------------------------------------------------------------
module pipeline_reg_wb_skid #(
    parameter int XLEN = 32,
    parameter int RD_W = 5
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            flush,
    input  logic            regwrite_in,
    input  logic            memtoreg_in,
    input  logic [XLEN-1:0] alu_result_in,
    input  logic [XLEN-1:0] mem_data_in,
    input  logic [RD_W-1:0] rd_in,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            regwrite_out,
    output logic            memtoreg_out,
    output logic [XLEN-1:0] alu_result_out,
    output logic [XLEN-1:0] mem_data_out,
    output logic [RD_W-1:0] rd_out,
    output logic [XLEN-1:0] wb_data_out,
    output logic [1:0]      occupancy
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_in_ready;

    logic            r_main_rw;
    logic            r_main_mtr;
    logic [XLEN-1:0] r_main_alu;
    logic [XLEN-1:0] r_main_mem;
    logic [RD_W-1:0] r_main_rd;

    logic            r_skid_rw;
    logic            r_skid_mtr;
    logic [XLEN-1:0] r_skid_alu;
    logic [XLEN-1:0] r_skid_mem;
    logic [RD_W-1:0] r_skid_rd;

    logic            w_accept;
    logic            w_consume;
    logic            w_load_main_in;
    logic            w_load_main_skid;
    logic            w_load_skid;
    logic            w_rw_in;

`ifdef PIPE_WB_X0_SUPPRESS_EN
    // x0 is hard-wired zero; dropping the enable here keeps it off the
    // register-file write port entirely.
    assign w_rw_in = regwrite_in & (rd_in != '0);
`else
    assign w_rw_in = regwrite_in;
`endif

    assign w_accept  = in_valid & r_in_ready;
    assign w_consume = (r_state != ST_EMPTY) & out_ready;

    always_comb begin
        w_state_nxt      = r_state;
        w_load_main_in   = 1'b0;
        w_load_main_skid = 1'b0;
        w_load_skid      = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_accept) begin
                    w_state_nxt    = ST_ONE;
                    w_load_main_in = 1'b1;
                end
            end
            ST_ONE: begin
                if (w_accept && w_consume) begin
                    w_load_main_in = 1'b1;
                end else if (w_accept) begin
                    w_state_nxt = ST_FULL;
                    w_load_skid = 1'b1;
                end else if (w_consume) begin
                    w_state_nxt = ST_EMPTY;
                end
            end
            ST_FULL: begin
                // in_ready is low here, so w_accept cannot be set
                if (w_consume) begin
                    w_state_nxt      = ST_ONE;
                    w_load_main_skid = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_EMPTY;
            end
        endcase
        // flush beats every other event, including a beat offered this cycle
        if (flush) begin
            w_state_nxt      = ST_EMPTY;
            w_load_main_in   = 1'b0;
            w_load_main_skid = 1'b0;
            w_load_skid      = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_EMPTY;
            r_in_ready <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            // ready is the registered image of the next state, so it never
            // depends combinationally on out_ready
            r_in_ready <= (w_state_nxt != ST_FULL);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_main_rw  <= 1'b0;
            r_main_mtr <= 1'b0;
            r_main_alu <= '0;
            r_main_mem <= '0;
            r_main_rd  <= '0;
        end else if (w_load_main_in) begin
            r_main_rw  <= w_rw_in;
            r_main_mtr <= memtoreg_in;
            r_main_alu <= alu_result_in;
            r_main_mem <= mem_data_in;
            r_main_rd  <= rd_in;
        end else if (w_load_main_skid) begin
            r_main_rw  <= r_skid_rw;
            r_main_mtr <= r_skid_mtr;
            r_main_alu <= r_skid_alu;
            r_main_mem <= r_skid_mem;
            r_main_rd  <= r_skid_rd;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_skid_rw  <= 1'b0;
            r_skid_mtr <= 1'b0;
            r_skid_alu <= '0;
            r_skid_mem <= '0;
            r_skid_rd  <= '0;
        end else if (w_load_skid) begin
            r_skid_rw  <= w_rw_in;
            r_skid_mtr <= memtoreg_in;
            r_skid_alu <= alu_result_in;
            r_skid_mem <= mem_data_in;
            r_skid_rd  <= rd_in;
        end
    end

    assign in_ready       = r_in_ready;
    assign out_valid      = (r_state != ST_EMPTY);
    assign occupancy      = r_state;
    assign regwrite_out   = r_main_rw & out_valid;
    assign memtoreg_out   = r_main_mtr;
    assign alu_result_out = r_main_alu;
    assign mem_data_out   = r_main_mem;
    assign rd_out         = r_main_rd;
    assign wb_data_out    = r_main_mtr ? r_main_mem : r_main_alu;

endmodule

// File: tb/tb_pipeline_reg_wb_skid.sv
// ---------------------------------------------------------------------------
// tb_pipeline_reg_wb_skid
//
// Bench for pipeline_reg_wb_skid: directed reset sequences, a vector table
// for the writeback, backpressure, flush, x0 and max-value scenarios, then
// randomized traffic against a queue-based reference model.
// ---------------------------------------------------------------------------
module tb_pipeline_reg_wb_skid;

    localparam int XLEN = 32;
    localparam int RD_W = 5;

`ifdef PIPE_WB_X0_SUPPRESS_EN
    localparam bit X0_SUP = 1'b1;
`else
    localparam bit X0_SUP = 1'b0;
`endif

    logic            clock = 1'b0;
    logic            reset;
    logic            in_valid;
    logic            in_ready;
    logic            flush;
    logic            regwrite_in;
    logic            memtoreg_in;
    logic [XLEN-1:0] alu_result_in;
    logic [XLEN-1:0] mem_data_in;
    logic [RD_W-1:0] rd_in;
    logic            out_valid;
    logic            out_ready;
    logic            regwrite_out;
    logic            memtoreg_out;
    logic [XLEN-1:0] alu_result_out;
    logic [XLEN-1:0] mem_data_out;
    logic [RD_W-1:0] rd_out;
    logic [XLEN-1:0] wb_data_out;
    logic [1:0]      occupancy;

    int checks   = 0;
    int failures = 0;

    pipeline_reg_wb_skid #(.XLEN(XLEN), .RD_W(RD_W)) dut (
        .clock          (clock),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .flush          (flush),
        .regwrite_in    (regwrite_in),
        .memtoreg_in    (memtoreg_in),
        .alu_result_in  (alu_result_in),
        .mem_data_in    (mem_data_in),
        .rd_in          (rd_in),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .regwrite_out   (regwrite_out),
        .memtoreg_out   (memtoreg_out),
        .alu_result_out (alu_result_out),
        .mem_data_out   (mem_data_out),
        .rd_out         (rd_out),
        .wb_data_out    (wb_data_out),
        .occupancy      (occupancy)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        iv, ordy, fl, rw, mtr;
        logic [31:0] alu, mem;
        logic [4:0]  rd;
        logic        e_ov, e_ir, e_rw;
        logic [1:0]  e_occ;
        logic [4:0]  e_rd;
        logic [31:0] e_alu, e_mem, e_wb;
    } vec_t;

    typedef struct {
        logic        rw, mtr;
        logic [31:0] alu, mem;
        logic [4:0]  rd;
    } beat_t;

    vec_t  vecs[$];
    beat_t q[$];
    beat_t last_main;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic add(input logic iv, input logic ordy, input logic fl, input logic rw,
                       input logic mtr, input logic [31:0] alu, input logic [31:0] mem,
                       input logic [4:0] rd, input logic e_ov, input logic e_ir,
                       input logic [1:0] e_occ, input logic e_rw, input logic [4:0] e_rd,
                       input logic [31:0] e_alu, input logic [31:0] e_mem,
                       input logic [31:0] e_wb);
        vec_t v;
        v.iv = iv; v.ordy = ordy; v.fl = fl; v.rw = rw; v.mtr = mtr;
        v.alu = alu; v.mem = mem; v.rd = rd;
        v.e_ov = e_ov; v.e_ir = e_ir; v.e_occ = e_occ; v.e_rw = e_rw; v.e_rd = e_rd;
        v.e_alu = e_alu; v.e_mem = e_mem; v.e_wb = e_wb;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic iv, input logic ordy, input logic fl, input logic rw,
                         input logic mtr, input logic [31:0] alu, input logic [31:0] mem,
                         input logic [4:0] rd);
        in_valid = iv; out_ready = ordy; flush = fl; regwrite_in = rw;
        memtoreg_in = mtr; alu_result_in = alu; mem_data_in = mem; rd_in = rd;
    endtask

    task automatic chk_idle_zero(input string tag);
        chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        chk({tag, "_occupancy"}, 64'(occupancy), 64'd0);
        chk({tag, "_regwrite"}, 64'(regwrite_out), 64'd0);
        chk({tag, "_memtoreg"}, 64'(memtoreg_out), 64'd0);
        chk({tag, "_alu"}, 64'(alu_result_out), 64'd0);
        chk({tag, "_mem"}, 64'(mem_data_out), 64'd0);
        chk({tag, "_rd"}, 64'(rd_out), 64'd0);
        chk({tag, "_wb"}, 64'(wb_data_out), 64'd0);
    endtask

    initial begin
        logic exp_rw, acc, cons;
        beat_t cur, nb;

        // ---- reset held with a beat offered -------------------------------
        reset = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h30, 32'h0, 5'd5);
        repeat (3) @(posedge clock);
        #1;
        chk_idle_zero("reset_hold");
        @(negedge clock);
        reset = 1'b1;

        // ---- vector table -----------------------------------------------
        //  iv or fl rw mt  alu           mem           rd   | ov ir occ rw rd  alu           mem           wb
        add(1, 0, 0, 1, 0, 32'h30,       32'h0,        5,     1, 1, 1, 1, 5,  32'h30,       32'h0,        32'h30);
        add(0, 1, 0, 0, 0, 32'h0,        32'h0,        0,     0, 1, 0, 0, 5,  32'h30,       32'h0,        32'h30);
        add(1, 1, 0, 1, 1, 32'h100,      32'hDEADBEEF, 3,     1, 1, 1, 1, 3,  32'h100,      32'hDEADBEEF, 32'hDEADBEEF);
        add(0, 1, 0, 0, 0, 32'h0,        32'h0,        0,     0, 1, 0, 0, 3,  32'h100,      32'hDEADBEEF, 32'hDEADBEEF);
        add(1, 0, 0, 1, 0, 32'h11,       32'h0,        1,     1, 1, 1, 1, 1,  32'h11,       32'h0,        32'h11);
        add(1, 0, 0, 1, 0, 32'h22,       32'h0,        2,     1, 0, 2, 1, 1,  32'h11,       32'h0,        32'h11);
        add(1, 0, 0, 1, 0, 32'h33,       32'h0,        3,     1, 0, 2, 1, 1,  32'h11,       32'h0,        32'h11);
        add(0, 1, 0, 0, 0, 32'h0,        32'h0,        0,     1, 1, 1, 1, 2,  32'h22,       32'h0,        32'h22);
        add(1, 1, 0, 1, 0, 32'h33,       32'h0,        3,     1, 1, 1, 1, 3,  32'h33,       32'h0,        32'h33);
        add(0, 1, 0, 0, 0, 32'h0,        32'h0,        0,     0, 1, 0, 0, 3,  32'h33,       32'h0,        32'h33);
        add(1, 0, 0, 1, 0, 32'h44,       32'h0,        4,     1, 1, 1, 1, 4,  32'h44,       32'h0,        32'h44);
        add(1, 0, 0, 1, 0, 32'h66,       32'h0,        6,     1, 0, 2, 1, 4,  32'h44,       32'h0,        32'h44);
        add(1, 0, 1, 1, 0, 32'h99,       32'h0,        9,     0, 1, 0, 0, 4,  32'h44,       32'h0,        32'h44);
        add(0, 1, 0, 0, 0, 32'h0,        32'h0,        0,     0, 1, 0, 0, 4,  32'h44,       32'h0,        32'h44);
        add(1, 0, 0, 1, 0, 32'h12345678, 32'h0,        0,     1, 1, 1, X0_SUP ? 1'b0 : 1'b1, 0, 32'h12345678, 32'h0, 32'h12345678);
        add(1, 1, 0, 1, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 31,    1, 1, 1, 1, 31, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
        add(0, 1, 0, 0, 0, 32'h0,        32'h0,        0,     0, 1, 0, 0, 31, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);

        foreach (vecs[i]) begin
            drive(vecs[i].iv, vecs[i].ordy, vecs[i].fl, vecs[i].rw, vecs[i].mtr,
                  vecs[i].alu, vecs[i].mem, vecs[i].rd);
            @(posedge clock);
            #1;
            chk($sformatf("vec%0d_out_valid", i), 64'(out_valid), 64'(vecs[i].e_ov));
            chk($sformatf("vec%0d_in_ready", i), 64'(in_ready), 64'(vecs[i].e_ir));
            chk($sformatf("vec%0d_occupancy", i), 64'(occupancy), 64'(vecs[i].e_occ));
            chk($sformatf("vec%0d_regwrite", i), 64'(regwrite_out), 64'(vecs[i].e_rw));
            chk($sformatf("vec%0d_rd", i), 64'(rd_out), 64'(vecs[i].e_rd));
            chk($sformatf("vec%0d_alu", i), 64'(alu_result_out), 64'(vecs[i].e_alu));
            chk($sformatf("vec%0d_mem", i), 64'(mem_data_out), 64'(vecs[i].e_mem));
            chk($sformatf("vec%0d_wb", i), 64'(wb_data_out), 64'(vecs[i].e_wb));
        end

        // ---- asynchronous reset while full --------------------------------
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'hA1, 32'hB1, 5'd7);
        @(posedge clock); #1;
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'hA2, 32'hB2, 5'd8);
        @(posedge clock); #1;
        chk("async_pre_occupancy", 64'(occupancy), 64'd2);
        #2;
        reset = 1'b0;
        #1;
        chk_idle_zero("async_reset");
        @(negedge clock);
        reset = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h55, 32'h0, 5'd10);
        @(posedge clock); #1;
        chk("after_reset_out_valid", 64'(out_valid), 64'd1);
        chk("after_reset_rd", 64'(rd_out), 64'd10);

        // ---- randomized traffic vs queue model ---------------------------
        reset = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        @(posedge clock); #1;
        reset = 1'b1;
        q.delete();
        last_main = '{rw: 1'b0, mtr: 1'b0, alu: 32'h0, mem: 32'h0, rd: 5'd0};

        for (int cyc = 0; cyc < 3000; cyc++) begin
            drive(1'($urandom_range(0, 99) < 60), 1'($urandom_range(0, 99) < 50),
                  1'($urandom_range(0, 99) < 4), 1'($urandom), 1'($urandom),
                  $urandom, $urandom, 5'($urandom_range(0, 31)));

            cur = (q.size() > 0) ? q[0] : last_main;
            chk("rnd_out_valid", 64'(out_valid), 64'(q.size() > 0));
            chk("rnd_in_ready", 64'(in_ready), 64'(q.size() < 2));
            chk("rnd_occupancy", 64'(occupancy), 64'(q.size()));
            chk("rnd_regwrite", 64'(regwrite_out), 64'((q.size() > 0) && cur.rw));
            chk("rnd_memtoreg", 64'(memtoreg_out), 64'(cur.mtr));
            chk("rnd_alu", 64'(alu_result_out), 64'(cur.alu));
            chk("rnd_mem", 64'(mem_data_out), 64'(cur.mem));
            chk("rnd_rd", 64'(rd_out), 64'(cur.rd));
            chk("rnd_wb", 64'(wb_data_out), 64'(cur.mtr ? cur.mem : cur.alu));

            if (flush) begin
                q.delete();
            end else begin
                acc  = in_valid && (q.size() < 2);
                cons = (q.size() > 0) && out_ready;
                if (cons) void'(q.pop_front());
                if (acc) begin
                    exp_rw = regwrite_in && !(X0_SUP && (rd_in == 5'd0));
                    nb = '{rw: exp_rw, mtr: memtoreg_in, alu: alu_result_in,
                           mem: mem_data_in, rd: rd_in};
                    q.push_back(nb);
                end
            end
            if (q.size() > 0) last_main = q[0];

            @(posedge clock);
            #1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
